// File: rtl/pipe_stage_skid_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_skid_if
// Purpose  : Bundles the upstream beat, downstream beat, flush and status
//            signals of one pipe_stage_skid instance.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Signals
//   in_valid / in_ready         upstream valid/ready handshake
//   in_pc / in_ctrl / in_data   upstream beat fields
//   flush                       kill beats held or accepted this cycle
//   out_valid / out_ready       downstream valid/ready handshake
//   out_pc / out_ctrl / out_data / out_flushed   presented beat
//   occupancy                   number of valid entries (0..2)
//   bubble_cnt                  saturating count of bubbles created
// Modports
//   master : the environment (upstream producer, downstream consumer)
//   slave  : the stage itself
// ============================================================================
interface pipe_stage_skid_if #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 101
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_pc;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_pc;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic              out_flushed;
  logic [1:0]        occupancy;
  logic [15:0]       bubble_cnt;

  modport master (
    output in_valid, in_pc, in_ctrl, in_data, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_ctrl, out_data, out_flushed,
           occupancy, bubble_cnt
  );

  modport slave (
    input  in_valid, in_pc, in_ctrl, in_data, flush, out_ready,
    output in_ready, out_valid, out_pc, out_ctrl, out_data, out_flushed,
           occupancy, bubble_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_skid
// Purpose  : Pipeline stage register with valid/ready handshake and a
//            2-entry skid buffer. Carries a PC, a clearable control vector
//            and an uncleared data payload. Flush either turns held beats
//            into marked bubbles (FLUSH_DROP=0) or discards them
//            (FLUSH_DROP=1). A saturating counter tracks bubbles created.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active low
//   bus  : pipe_stage_skid_if.slave (upstream, downstream, flush, status)
// Parameters
//   CTRL_W     : control field width (cleared on flush)
//   DATA_W     : payload width (never cleared)
//   FLUSH_DROP : 0 = bubble held beats, 1 = drop held beats
// ============================================================================
module pipe_stage_skid #(
  parameter int CTRL_W     = 16,
  parameter int DATA_W     = 101,
  parameter int FLUSH_DROP = 0
) (
  input  logic                clk,
  input  logic                rst,
  pipe_stage_skid_if.slave    bus
);

  // State doubles as the occupancy count.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0]       pc;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
    logic              flushed;
  } entry_t;

  state_t      r_state;
  state_t      w_state;
  entry_t      r_main;
  entry_t      r_skid;
  entry_t      w_main;
  entry_t      w_skid;
  entry_t      w_in;
  logic        r_in_ready;
  logic        w_push;
  logic        w_pop;
  logic [15:0] r_bubble_cnt;
  logic [15:0] w_bubble_cnt;
  logic [1:0]  w_new_bubbles;
  logic [16:0] w_bubble_sum;

  always_comb begin
    w_in          = '{pc: bus.in_pc, ctrl: bus.in_ctrl, data: bus.in_data, flushed: 1'b0};
    w_push        = bus.in_valid & r_in_ready;
    w_pop         = (r_state != S_EMPTY) & bus.out_ready;
    w_state       = r_state;
    w_main        = r_main;
    w_skid        = r_skid;
    w_new_bubbles = 2'd0;

    // Normal movement first; flush is applied to the post-movement view.
    case (r_state)
      S_EMPTY: begin
        if (w_push) begin
          w_main  = w_in;
          w_state = S_ONE;
        end
      end
      S_ONE: begin
        if (w_push && w_pop) begin
          w_main = w_in;
        end else if (w_push) begin
          w_skid  = w_in;
          w_state = S_TWO;
        end else if (w_pop) begin
          w_state = S_EMPTY;
        end
      end
      S_TWO: begin
        // in_ready is low here, so only a pop can happen.
        if (w_pop) begin
          w_main  = r_skid;
          w_state = S_ONE;
        end
      end
      default: w_state = S_EMPTY;
    endcase

    if (bus.flush) begin
      if (FLUSH_DROP != 0) begin
        w_state = S_EMPTY;
      end else begin
        // Only entries not already bubbled count toward the debug counter.
        w_new_bubbles = {1'b0, (w_state != S_EMPTY) && !w_main.flushed}
                      + {1'b0, (w_state == S_TWO)   && !w_skid.flushed};
        if (w_state != S_EMPTY) begin
          w_main.ctrl    = '0;
          w_main.flushed = 1'b1;
        end
        if (w_state == S_TWO) begin
          w_skid.ctrl    = '0;
          w_skid.flushed = 1'b1;
        end
      end
    end

    w_bubble_sum = {1'b0, r_bubble_cnt} + {15'd0, w_new_bubbles};
    w_bubble_cnt = w_bubble_sum[16] ? 16'hFFFF : w_bubble_sum[15:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_EMPTY;
      r_main       <= '0;
      r_skid       <= '0;
      r_in_ready   <= 1'b0;
      r_bubble_cnt <= 16'd0;
    end else begin
      r_state      <= w_state;
      r_main       <= w_main;
      r_skid       <= w_skid;
      // Ready whenever the next state still has a free entry.
      r_in_ready   <= (w_state != S_TWO);
      r_bubble_cnt <= w_bubble_cnt;
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.out_valid   = (r_state != S_EMPTY);
  assign bus.out_pc      = r_main.pc;
  assign bus.out_ctrl    = r_main.ctrl;
  assign bus.out_data    = r_main.data;
  assign bus.out_flushed = r_main.flushed;
  assign bus.occupancy   = r_state;
  assign bus.bubble_cnt  = r_bubble_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_skid
// Purpose  : Directed self-checking bench. Two stages share one stimulus:
//            u_dut_b bubbles on flush, u_dut_d drops on flush.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_skid;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [31:0]  in_pc;
  logic [15:0]  in_ctrl;
  logic [100:0] in_data;
  logic         flush;
  logic         out_ready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stage_skid_if #(.CTRL_W(16), .DATA_W(101)) bus_b ();
  pipe_stage_skid_if #(.CTRL_W(16), .DATA_W(101)) bus_d ();

  assign bus_b.in_valid  = in_valid;
  assign bus_b.in_pc     = in_pc;
  assign bus_b.in_ctrl   = in_ctrl;
  assign bus_b.in_data   = in_data;
  assign bus_b.flush     = flush;
  assign bus_b.out_ready = out_ready;
  assign bus_d.in_valid  = in_valid;
  assign bus_d.in_pc     = in_pc;
  assign bus_d.in_ctrl   = in_ctrl;
  assign bus_d.in_data   = in_data;
  assign bus_d.flush     = flush;
  assign bus_d.out_ready = out_ready;

  pipe_stage_skid #(.CTRL_W(16), .DATA_W(101), .FLUSH_DROP(0)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  pipe_stage_skid #(.CTRL_W(16), .DATA_W(101), .FLUSH_DROP(1)) u_dut_d (
    .clk (clk),
    .rst (rst),
    .bus (bus_d)
  );

  function automatic logic [100:0] mk_data(input logic [31:0] pc);
    return {5'h15, ~pc, 32'hCAFE_F00D, pc};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [15:0] ctrl);
    in_valid = v;
    in_pc    = pc;
    in_ctrl  = ctrl;
    in_data  = mk_data(pc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_b(input string tag);
    chk({tag, "_valid"},   bus_b.out_valid,   1'b0);
    chk({tag, "_occ"},     bus_b.occupancy,   2'd0);
    chk({tag, "_pc"},      bus_b.out_pc,      32'd0);
    chk({tag, "_ctrl"},    bus_b.out_ctrl,    16'd0);
    chk({tag, "_data"},    bus_b.out_data,    101'd0);
    chk({tag, "_flushed"}, bus_b.out_flushed, 1'b0);
    chk({tag, "_bcnt"},    bus_b.bubble_cnt,  16'd0);
    chk({tag, "_ready"},   bus_b.in_ready,    1'b0);
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 32'h0, 16'h0);
    #2 rst = 1'b0;
    #1;
    chk_reset_b("rst");
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold_ready", bus_b.in_ready, 1'b0);
    rst = 1'b1;
    step();
    chk("rel_ready", bus_b.in_ready, 1'b1);
    chk("rel_valid", bus_b.out_valid, 1'b0);

    // Streaming, out_ready high
    out_ready = 1'b1;
    drive(1'b1, 32'h0, 16'h1111);
    step();
    chk("s0_pc", bus_b.out_pc, 32'h0);
    chk("s0_valid", bus_b.out_valid, 1'b1);
    chk("s0_occ", bus_b.occupancy, 2'd1);
    chk("s0_ready", bus_b.in_ready, 1'b1);
    drive(1'b1, 32'h4, 16'h2222);
    step();
    chk("s1_pc", bus_b.out_pc, 32'h4);
    chk("s1_ctrl", bus_b.out_ctrl, 16'h2222);
    chk("s1_data", bus_b.out_data, mk_data(32'h4));
    chk("s1_occ", bus_b.occupancy, 2'd1);
    drive(1'b1, 32'h8, 16'h3333);
    step();
    chk("s2_pc", bus_b.out_pc, 32'h8);
    chk("s2_occ", bus_b.occupancy, 2'd1);
    drive(1'b0, 32'h0, 16'h0);
    step();
    chk("s3_valid", bus_b.out_valid, 1'b0);
    chk("s3_occ", bus_b.occupancy, 2'd0);
    chk("s3_bcnt", bus_b.bubble_cnt, 16'd0);

    // Back-pressure
    out_ready = 1'b0;
    drive(1'b1, 32'h100, 16'h0100);
    step();
    chk("bp0_pc", bus_b.out_pc, 32'h100);
    chk("bp0_ready", bus_b.in_ready, 1'b1);
    drive(1'b1, 32'h104, 16'h0104);
    step();
    chk("bp1_occ", bus_b.occupancy, 2'd2);
    chk("bp1_ready", bus_b.in_ready, 1'b0);
    chk("bp1_pc", bus_b.out_pc, 32'h100);
    drive(1'b0, 32'h0, 16'h0);
    step();
    chk("bp2_pc_held", bus_b.out_pc, 32'h100);
    chk("bp2_ctrl_held", bus_b.out_ctrl, 16'h0100);
    out_ready = 1'b1;
    step();
    chk("bp3_pc", bus_b.out_pc, 32'h104);
    chk("bp3_ctrl", bus_b.out_ctrl, 16'h0104);
    chk("bp3_occ", bus_b.occupancy, 2'd1);
    chk("bp3_ready", bus_b.in_ready, 1'b1);
    step();
    chk("bp4_valid", bus_b.out_valid, 1'b0);

    // Flush in TWO: bubble on u_dut_b, drop on u_dut_d
    out_ready = 1'b0;
    drive(1'b1, 32'h200, 16'hFFFF);
    step();
    drive(1'b1, 32'h204, 16'hFFFF);
    step();
    chk("fl_pre_occ_b", bus_b.occupancy, 2'd2);
    chk("fl_pre_occ_d", bus_d.occupancy, 2'd2);
    drive(1'b1, 32'h208, 16'hFFFF);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 16'h0);
    chk("fb_occ", bus_b.occupancy, 2'd2);
    chk("fb_pc", bus_b.out_pc, 32'h200);
    chk("fb_ctrl", bus_b.out_ctrl, 16'h0);
    chk("fb_flushed", bus_b.out_flushed, 1'b1);
    chk("fb_data", bus_b.out_data, mk_data(32'h200));
    chk("fb_bcnt", bus_b.bubble_cnt, 16'd2);
    chk("fd_occ", bus_d.occupancy, 2'd0);
    chk("fd_valid", bus_d.out_valid, 1'b0);
    chk("fd_bcnt", bus_d.bubble_cnt, 16'd0);
    chk("fd_ready", bus_d.in_ready, 1'b1);
    out_ready = 1'b1;
    step();
    chk("fb2_pc", bus_b.out_pc, 32'h204);
    chk("fb2_ctrl", bus_b.out_ctrl, 16'h0);
    chk("fb2_flushed", bus_b.out_flushed, 1'b1);
    chk("fb2_data", bus_b.out_data, mk_data(32'h204));
    chk("fd2_valid", bus_d.out_valid, 1'b0);
    step();
    chk("fb3_valid", bus_b.out_valid, 1'b0);
    chk("fb3_bcnt", bus_b.bubble_cnt, 16'd2);

    // Push + pop + flush in ONE
    out_ready = 1'b0;
    drive(1'b1, 32'h300, 16'hA5A5);
    step();
    out_ready = 1'b1;
    drive(1'b1, 32'h304, 16'h5A5A);
    flush = 1'b1;
    chk("sim_pop_pc", bus_b.out_pc, 32'h300);
    chk("sim_pop_ctrl", bus_b.out_ctrl, 16'hA5A5);
    chk("sim_pop_flushed", bus_b.out_flushed, 1'b0);
    chk("sim_pop_pc_d", bus_d.out_pc, 32'h300);
    step();
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 32'h0, 16'h0);
    chk("sim_b_pc", bus_b.out_pc, 32'h304);
    chk("sim_b_ctrl", bus_b.out_ctrl, 16'h0);
    chk("sim_b_flushed", bus_b.out_flushed, 1'b1);
    chk("sim_b_occ", bus_b.occupancy, 2'd1);
    chk("sim_b_bcnt", bus_b.bubble_cnt, 16'd3);
    chk("sim_d_occ", bus_d.occupancy, 2'd0);
    chk("sim_d_valid", bus_d.out_valid, 1'b0);
    out_ready = 1'b1;
    step();
    chk("sim_b_drain", bus_b.out_valid, 1'b0);
    chk("sim_d_never", bus_d.out_valid, 1'b0);

    // Saturation: one new bubble per edge
    rst = 1'b0;
    #1;
    rst = 1'b1;
    step();
    chk("sat_ready", bus_b.in_ready, 1'b1);
    drive(1'b1, 32'h400, 16'h7777);
    flush = 1'b1;
    out_ready = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_fffe", bus_b.bubble_cnt, 16'hFFFE);
    step();
    chk("sat_ffff", bus_b.bubble_cnt, 16'hFFFF);
    repeat (3) @(posedge clk);
    #1;
    chk("sat_hold", bus_b.bubble_cnt, 16'hFFFF);
    chk("sat_d_bcnt", bus_d.bubble_cnt, 16'd0);

    // Async reset in the middle of a stall
    flush = 1'b0;
    out_ready = 1'b0;
    step();
    chk("stall_occ", bus_b.occupancy, 2'd2);
    chk("stall_ready", bus_b.in_ready, 1'b0);
    #3;
    rst = 1'b0;
    #1;
    chk_reset_b("arst");
    chk("arst_d_occ", bus_d.occupancy, 2'd0);
    rst = 1'b1;
    drive(1'b0, 32'h0, 16'h0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
